// File: rtl/state_mem_sequencer_pkg.sv
// Shared definitions for the state memory sequencer.
// Holds the memory geometry (row/column widths, element counts), the view
// encoding used on mem_mode, the FSM state encoding and a helper that gives
// the last element index for a pass.
package state_mem_sequencer_pkg;

  localparam int ROW_W      = 25;  // slice view element width
  localparam int COL_W      = 64;  // lane view element width
  localparam int NUM_SLICES = 64;  // elements in a slice pass
  localparam int NUM_LANES  = 25;  // elements in a lane pass
  localparam int IDX_W      = 6;   // wide enough for 0..NUM_SLICES-1
  localparam int LANE_ADR_W = 5;   // column address width

  localparam logic MODE_LANE  = 1'b0;
  localparam logic MODE_SLICE = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_SEND,
    ST_WAIT,
    ST_WR,
    ST_NEXT,
    ST_DUMP,
    ST_DONE
  } seq_state_e;

  // Index of the final element of a pass in the given view.
  function automatic logic [IDX_W-1:0] last_index(input logic mode,
                                                  input int   slices,
                                                  input int   lanes);
    return (mode == MODE_SLICE) ? IDX_W'(slices - 1) : IDX_W'(lanes - 1);
  endfunction

endpackage

// File: rtl/state_mem_sequencer_index_counter.sv
// Element index counter for the state memory sequencer.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - load zero (takes priority over inc)
//   inc        - advance by one
//   last_idx   - index of the final element of the current pass
//   idx        - current element index
//   last       - idx is the final element
module seq_index_counter
  import state_mem_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [IDX_W-1:0] last_idx,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (inc) begin
      idx <= idx + 1'b1;
    end
  end

  assign last = (idx == last_idx);

endmodule

// File: rtl/state_mem_sequencer.sv
// Initiator-side controller for the dual-view 64x25 state memory.
// Walks every element of one view (64 rows of 25 bits, or 25 columns of
// 64 bits): read it, send it to a processing element, take the result back
// and write it to the same address. Optionally pulses the dump strobe at
// the end of the pass.
// Ports:
//   start/pass_mode       - begin a pass (accepted only when idle), view select
//   busy/done             - pass in progress / one-cycle completion pulse
//   mem_mode              - memory view select (0 lane, 1 slice)
//   mem_adr25..mem_out25  - slice view port
//   mem_adr64..mem_out64  - lane view port
//   mem_wr_file           - memory dump strobe
//   pe_data_o/valid_o/ready_i - element towards the PE
//   pe_data_i/valid_i/ready_o - result from the PE
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The sender keeps valid and data stable until that edge; the
// receiver may hold ready low for any number of cycles.
module state_mem_sequencer
  import state_mem_sequencer_pkg::*;
#(
  parameter int SLICES       = NUM_SLICES,
  parameter int LANES        = NUM_LANES,
  parameter int DUMP_ON_DONE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  pass_mode,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_mode,
  output logic [IDX_W-1:0]      mem_adr25,
  output logic [ROW_W-1:0]      mem_in25,
  output logic                  mem_r25,
  output logic                  mem_w25,
  input  logic [ROW_W-1:0]      mem_out25,
  output logic [LANE_ADR_W-1:0] mem_adr64,
  output logic [COL_W-1:0]      mem_in64,
  output logic                  mem_r64,
  output logic                  mem_w64,
  input  logic [COL_W-1:0]      mem_out64,
  output logic                  mem_wr_file,
  output logic [COL_W-1:0]      pe_data_o,
  output logic                  pe_valid_o,
  input  logic                  pe_ready_i,
  input  logic [COL_W-1:0]      pe_data_i,
  input  logic                  pe_valid_i,
  output logic                  pe_ready_o
);

  seq_state_e       state_q, state_d;
  logic             mode_q;
  logic [COL_W-1:0] data_q;
  logic [COL_W-1:0] res_q;
  logic [IDX_W-1:0] idx;
  logic             idx_last;
  logic             idx_clr;
  logic             idx_inc;
  logic             slice;
  logic             elem_phase;

  seq_index_counter u_index (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (idx_clr),
    .inc      (idx_inc),
    .last_idx (last_index(mode_q, SLICES, LANES)),
    .idx      (idx),
    .last     (idx_last)
  );

  // ---------------- state register and latched pass data ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_LANE;
      data_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        mode_q <= pass_mode;
      end
      // Slice elements are zero-extended so the PE always sees a 64-bit word.
      if (state_q == ST_CAP) begin
        data_q <= (mode_q == MODE_SLICE) ? {{(COL_W-ROW_W){1'b0}}, mem_out25}
                                         : mem_out64;
      end
      if (state_q == ST_WAIT && pe_valid_i) begin
        res_q <= (mode_q == MODE_SLICE) ? {{(COL_W-ROW_W){1'b0}}, pe_data_i[ROW_W-1:0]}
                                        : pe_data_i;
      end
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    idx_clr = 1'b0;
    idx_inc = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_clr = 1'b1;
          state_d = ST_RD;
        end
      end
      ST_RD:   state_d = ST_CAP;
      ST_CAP:  state_d = ST_SEND;
      ST_SEND: if (pe_ready_i) state_d = ST_WAIT;
      ST_WAIT: if (pe_valid_i) state_d = ST_WR;
      ST_WR:   state_d = ST_NEXT;
      ST_NEXT: begin
        if (idx_last) begin
          state_d = (DUMP_ON_DONE != 0) ? ST_DUMP : ST_DONE;
        end else begin
          idx_inc = 1'b1;
          state_d = ST_RD;
        end
      end
      ST_DUMP: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  // All outputs decode from registered state, so an asynchronous reset
  // clears every enable immediately and no write can follow it.
  assign slice      = (mode_q == MODE_SLICE);
  // The address is held for the whole element, including the settle cycle
  // after the write, and only on the port of the active view.
  assign elem_phase = (state_q == ST_RD)   || (state_q == ST_CAP) ||
                      (state_q == ST_SEND) || (state_q == ST_WAIT) ||
                      (state_q == ST_WR)   || (state_q == ST_NEXT);

  always_comb begin
    busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
    done        = (state_q == ST_DONE);
    mem_mode    = mode_q;
    mem_wr_file = (state_q == ST_DUMP);

    mem_adr25 = (elem_phase && slice)  ? idx : '0;
    mem_adr64 = (elem_phase && !slice) ? idx[LANE_ADR_W-1:0] : '0;

    mem_r25 = ((state_q == ST_RD) || (state_q == ST_CAP)) && slice;
    mem_r64 = ((state_q == ST_RD) || (state_q == ST_CAP)) && !slice;
    mem_w25 = (state_q == ST_WR) && slice;
    mem_w64 = (state_q == ST_WR) && !slice;

    mem_in25 = mem_w25 ? res_q[ROW_W-1:0] : '0;
    mem_in64 = mem_w64 ? res_q : '0;

    pe_valid_o = (state_q == ST_SEND);
    pe_data_o  = (state_q == ST_SEND) ? data_q : '0;
    pe_ready_o = (state_q == ST_WAIT);
  end

endmodule

// File: tb/tb_state_mem_sequencer.sv
// Bench for state_mem_sequencer: memory model, PE model, directed pass table
// and hand-written reset / dump-disabled sequences.
module tb_state_mem_sequencer;
  import state_mem_sequencer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 1 (dump enabled) ----------------
  logic        start, pass_mode;
  logic        busy, done, mem_mode, mem_r25, mem_w25, mem_r64, mem_w64, mem_wr_file;
  logic [5:0]  mem_adr25;
  logic [24:0] mem_in25;
  logic [24:0] mem_out25 = '0;
  logic [4:0]  mem_adr64;
  logic [63:0] mem_in64;
  logic [63:0] mem_out64 = '0;
  logic [63:0] pe_data_o, pe_data_i;
  logic        pe_valid_o, pe_ready_i, pe_valid_i, pe_ready_o;

  state_mem_sequencer #(.SLICES(64), .LANES(25), .DUMP_ON_DONE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pass_mode(pass_mode),
    .busy(busy), .done(done), .mem_mode(mem_mode),
    .mem_adr25(mem_adr25), .mem_in25(mem_in25), .mem_r25(mem_r25), .mem_w25(mem_w25),
    .mem_out25(mem_out25),
    .mem_adr64(mem_adr64), .mem_in64(mem_in64), .mem_r64(mem_r64), .mem_w64(mem_w64),
    .mem_out64(mem_out64), .mem_wr_file(mem_wr_file),
    .pe_data_o(pe_data_o), .pe_valid_o(pe_valid_o), .pe_ready_i(pe_ready_i),
    .pe_data_i(pe_data_i), .pe_valid_i(pe_valid_i), .pe_ready_o(pe_ready_o)
  );

  // ---------------- DUT 2 (dump disabled, trivial memory and PE) ----------------
  logic        d2_start, d2_pass_mode, d2_pe_ready_i, d2_pe_valid_i;
  logic [24:0] d2_mem_out25;
  logic [63:0] d2_mem_out64, d2_pe_data_i;
  logic        d2_busy, d2_done, d2_mem_mode, d2_r25, d2_w25, d2_r64, d2_w64, d2_wr_file;
  logic [5:0]  d2_adr25;
  logic [24:0] d2_in25;
  logic [4:0]  d2_adr64;
  logic [63:0] d2_in64, d2_pe_data_o;
  logic        d2_pe_valid_o, d2_pe_ready_o;

  state_mem_sequencer #(.SLICES(64), .LANES(25), .DUMP_ON_DONE(0)) dut_nodump (
    .clk(clk), .rst_n(rst_n), .start(d2_start), .pass_mode(d2_pass_mode),
    .busy(d2_busy), .done(d2_done), .mem_mode(d2_mem_mode),
    .mem_adr25(d2_adr25), .mem_in25(d2_in25), .mem_r25(d2_r25), .mem_w25(d2_w25),
    .mem_out25(d2_mem_out25),
    .mem_adr64(d2_adr64), .mem_in64(d2_in64), .mem_r64(d2_r64), .mem_w64(d2_w64),
    .mem_out64(d2_mem_out64), .mem_wr_file(d2_wr_file),
    .pe_data_o(d2_pe_data_o), .pe_valid_o(d2_pe_valid_o), .pe_ready_i(d2_pe_ready_i),
    .pe_data_i(d2_pe_data_i), .pe_valid_i(d2_pe_valid_i), .pe_ready_o(d2_pe_ready_o)
  );

  // ---------------- memory model (dual view over 64 rows of 25 bits) ----------------
  logic [24:0] rows [64];
  logic [24:0] pre_rows [64];
  int          preload_seq = 0;
  int          preload_seen = 0;

  function automatic logic [63:0] col_of(input logic [4:0] c);
    logic [63:0] v;
    for (int r = 0; r < 64; r++) v[r] = rows[r][c];
    return v;
  endfunction

  always @(posedge clk) begin
    if (preload_seq != preload_seen) begin
      preload_seen <= preload_seq;
      for (int r = 0; r < 64; r++) rows[r] <= pre_rows[r];
    end else begin
      if (mem_r25) mem_out25 <= rows[mem_adr25];
      if (mem_r64) mem_out64 <= col_of(mem_adr64);
      if (mem_w25) rows[mem_adr25] <= mem_in25;
      if (mem_w64) for (int r = 0; r < 64; r++) rows[r][mem_adr64] <= mem_in64[r];
    end
  end

  // ---------------- PE model ----------------
  logic        pe_inv = 1'b0;
  int          stall_at = 0;
  int          stall_len = 0;
  int          pass_id = 0;
  int          stall_total = 0;
  int          stall_viol = 0;

  initial begin
    int          seen_id;
    int          hs_cnt;
    int          stalled;
    logic [63:0] hold;
    seen_id = 0; hs_cnt = 0; stalled = 0; hold = '0;
    pe_ready_i = 1'b1;
    pe_valid_i = 1'b1;
    pe_data_i  = '0;
    forever begin
      @(negedge clk);
      if (pass_id != seen_id) begin
        seen_id = pass_id; hs_cnt = 0; stalled = 0;
      end
      pe_ready_i = 1'b1;
      if (pe_valid_o && hs_cnt == stall_at && stalled < stall_len) begin
        if (stalled == 0) hold = pe_data_o;
        else if (pe_data_o !== hold) stall_viol++;
        if (mem_w25 || mem_w64) stall_viol++;
        pe_ready_i = 1'b0;
        stalled++;
        stall_total++;
      end
      if (pe_valid_o && pe_ready_i) begin
        pe_data_i = pe_inv ? ~pe_data_o : pe_data_o;
        hs_cnt++;
      end
    end
  end

  // ---------------- monitor ----------------
  logic       cur_mode = 1'b0;
  int         n_w25 = 0, n_w64 = 0, n_r25 = 0, n_r64 = 0, n_dump = 0, n_done = 0, n_viol = 0;
  logic [5:0] act_q [$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_w25) begin n_w25++; act_q.push_back(mem_adr25); end
      if (mem_w64) begin n_w64++; act_q.push_back({1'b0, mem_adr64}); end
      if (mem_r25) n_r25++;
      if (mem_r64) n_r64++;
      if (mem_wr_file) n_dump++;
      if ((mem_r25 || mem_r64) && (mem_w25 || mem_w64)) n_viol++;
      if (busy && mem_mode !== cur_mode) n_viol++;
      if (cur_mode == MODE_SLICE && (mem_r64 || mem_w64)) n_viol++;
      if (cur_mode == MODE_LANE && (mem_r25 || mem_w25)) n_viol++;
      if (cur_mode == MODE_SLICE && pe_valid_o && pe_data_o[63:25] != '0) n_viol++;
    end
    if (done) n_done++;
  end

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [5:0] exp_q [$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill_rows(input int kind);
    for (int r = 0; r < 64; r++) begin
      case (kind)
        0:       pre_rows[r] = '0;
        1:       pre_rows[r] = 25'(r);
        default: pre_rows[r] = 25'((r * 40503) ^ 32'h015A_5A5A);
      endcase
    end
    preload_seq++;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int count_bad_rows(input logic inv, input int upto);
    int bad;
    logic [24:0] e;
    bad = 0;
    for (int r = 0; r < 64; r++) begin
      e = (inv && r < upto) ? ~pre_rows[r] : pre_rows[r];
      if (rows[r] !== e) bad++;
    end
    return bad;
  endfunction

  typedef struct {
    logic mode;
    logic inv;
    int   fill;       // 0 zero, 1 row index, 2 fixed pattern
    int   stall_at;
    int   stall_len;
    int   poke_cyc;   // cycle at which a stray start is pulsed (0 = none)
    int   exp_cyc;    // cycle of the done pulse, start cycle = 0
    int   exp_w25;
    int   exp_w64;
    int   exp_dump;
  } vec_t;

  vec_t vecs [5];

  task automatic run_pass(input vec_t v, output int cyc, output logic busy_first,
                          output logic busy_at_done, output logic done_seen);
    pass_id++;
    pe_inv    = v.inv;
    stall_at  = v.stall_at;
    stall_len = v.stall_len;
    cur_mode  = v.mode;
    start     = 1'b1;
    pass_mode = v.mode;
    cyc = 0; done_seen = 1'b0; busy_first = 1'b0; busy_at_done = 1'b1;
    while (cyc < 3000 && !done_seen) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin start = 1'b0; busy_first = busy; end
      if (v.poke_cyc != 0 && cyc == v.poke_cyc) begin start = 1'b1; pass_mode = ~v.mode; end
      if (v.poke_cyc != 0 && cyc == v.poke_cyc + 1) begin start = 1'b0; pass_mode = v.mode; end
      if (done) begin done_seen = 1'b1; busy_at_done = busy; end
    end
  endtask

  // ---------------- main test ----------------
  initial begin
    int   cyc, n_elem, base, mism, k;
    logic b_first, b_done, seen;
    int   s_w25, s_w64, s_r25, s_r64, s_dump, s_done, s_viol, s_stall, s_sviol;

    start = 1'b0; pass_mode = 1'b0;
    d2_start = 1'b0; d2_pass_mode = MODE_SLICE; d2_pe_ready_i = 1'b1; d2_pe_valid_i = 1'b1;
    d2_mem_out25 = '0; d2_mem_out64 = '0; d2_pe_data_i = '0;

    //              mode        inv   fill stall len poke  cyc  w25 w64 dump
    vecs[0] = '{MODE_SLICE, 1'b0, 1,   0,   0,  0,   386, 64, 0,  1};
    vecs[1] = '{MODE_LANE,  1'b1, 0,   0,   0,  0,   152, 0,  25, 1};
    vecs[2] = '{MODE_SLICE, 1'b1, 1,   3,   10, 0,   396, 64, 0,  1};
    vecs[3] = '{MODE_LANE,  1'b0, 2,   0,   3,  0,   155, 0,  25, 1};
    vecs[4] = '{MODE_SLICE, 1'b0, 1,   0,   0,  61,  386, 64, 0,  1};

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_all_outputs", |{busy, done, mem_mode, mem_r25, mem_w25, mem_r64, mem_w64,
          mem_wr_file, pe_valid_o, pe_ready_o, mem_adr25, mem_adr64, mem_in25, mem_in64,
          pe_data_o}, 0);
    check("reset_nodump_outputs", |{d2_busy, d2_done, d2_mem_mode, d2_r25, d2_w25, d2_r64,
          d2_w64, d2_wr_file, d2_pe_valid_o, d2_pe_ready_o}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table of full passes.
    for (int i = 0; i < 5; i++) begin
      fill_rows(vecs[i].fill);
      n_elem = (vecs[i].mode == MODE_SLICE) ? 64 : 25;
      s_w25 = n_w25; s_w64 = n_w64; s_r25 = n_r25; s_r64 = n_r64; s_dump = n_dump;
      s_done = n_done; s_viol = n_viol; s_stall = stall_total; s_sviol = stall_viol;
      base = act_q.size();
      run_pass(vecs[i], cyc, b_first, b_done, seen);
      check($sformatf("v%0d_done_seen", i), seen, 1);
      check($sformatf("v%0d_done_cycle", i), cyc, vecs[i].exp_cyc);
      check($sformatf("v%0d_busy_after_start", i), b_first, 1);
      check($sformatf("v%0d_busy_at_done", i), b_done, 0);
      @(negedge clk);
      check($sformatf("v%0d_done_pulses", i), n_done - s_done, 1);
      check($sformatf("v%0d_w25_pulses", i), n_w25 - s_w25, vecs[i].exp_w25);
      check($sformatf("v%0d_w64_pulses", i), n_w64 - s_w64, vecs[i].exp_w64);
      check($sformatf("v%0d_r25_cycles", i), n_r25 - s_r25, 2 * vecs[i].exp_w25);
      check($sformatf("v%0d_r64_cycles", i), n_r64 - s_r64, 2 * vecs[i].exp_w64);
      check($sformatf("v%0d_dump_pulses", i), n_dump - s_dump, vecs[i].exp_dump);
      check($sformatf("v%0d_protocol", i), n_viol - s_viol, 0);
      check($sformatf("v%0d_stall_cycles", i), stall_total - s_stall, vecs[i].stall_len);
      check($sformatf("v%0d_stall_stable", i), stall_viol - s_sviol, 0);
      for (int a = 0; a < n_elem; a++) exp_q.push_back(6'(a));
      mism = 0;
      for (int a = 0; a < n_elem; a++) begin
        if (base + a >= act_q.size()) mism++;
        else if (act_q[base + a] !== exp_q.pop_front()) mism++;
      end
      exp_q.delete();
      check($sformatf("v%0d_write_addr_seq", i), mism, 0);
      check($sformatf("v%0d_rows", i), count_bad_rows(vecs[i].inv, 64), 0);
      check($sformatf("v%0d_idle_busy", i), busy, 0);
    end

    // Reset during the write of element 5 of an inverting slice pass.
    fill_rows(1);
    pass_id++; pe_inv = 1'b1; stall_len = 0; cur_mode = MODE_SLICE;
    s_done = n_done;
    start = 1'b1; pass_mode = MODE_SLICE;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(mem_w25 && mem_adr25 == 6'd5) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("rst_mid_reached_wr5", (k < 1000), 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs_zero", |{busy, done, mem_mode, mem_r25, mem_w25, mem_r64, mem_w64,
          mem_wr_file, pe_valid_o, pe_ready_o, mem_adr25, mem_adr64, mem_in25, mem_in64,
          pe_data_o}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_mid_no_done", n_done - s_done, 0);
    check("rst_mid_idle", busy, 0);
    check("rst_mid_rows", count_bad_rows(1'b1, 5), 0);

    // Dump disabled: slice pass ends one cycle earlier with no dump strobe.
    d2_start = 1'b1; d2_pass_mode = MODE_SLICE;
    cyc = 0; seen = 1'b0; k = 0;
    while (cyc < 3000 && !seen) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (cyc == 1) d2_start = 1'b0;
      if (d2_wr_file) k++;
      if (d2_done) seen = 1'b1;
    end
    check("nodump_done_seen", seen, 1);
    check("nodump_done_cycle", cyc, 385);
    check("nodump_dump_pulses", k, 0);
    check("nodump_mode_slice", d2_mem_mode, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
